pe_cfg_dispatcher: RTL and testbench
====================================

// Module: pe_cfg_dispatcher
// PURPOSE
//  Streams configuration packets from one valid/ready source to NUM_PE PE_top
//  PE_Configure_Inport ports, replacing per-PE hand-driven config registers.
//  Each packet is one header word (destination, word count) plus N data words.
//  Each data word goes to the addressed PE, or to all PEs on broadcast, as a
//  one-cycle {1'b1,word} strobe. Sits between the host/config bus and the PE array.
// PARAMETERS
//  NUM_PE     4   number of PE config ports (1..255)
//  CFG_W      32  config word width; each PE port is CFG_W+1 ({valid,word})
//  MAX_WORDS  8   max data words per packet (1..255)
// PORTS
//  clk           in   1                clock, rising edge
//  reset         in   1                asynchronous, active-low reset
//  s_cfg_valid   in   1                source word valid
//  s_cfg_ready   out  1                dispatcher accepts word this cycle
//  s_cfg_data    in   CFG_W            header or data word
//  s_cfg_last    in   1                final word of packet
//  pe_cfg_stall  in   NUM_PE           per-PE hold request; bit i stalls PE i
//  pe_cfg_port   out  NUM_PE*(CFG_W+1) flat; slice i = PE i {valid,word}
//  cfg_done      out  1                pulse: packet delivered cleanly
//  cfg_err       out  1                pulse: packet malformed or dropped
//  cfg_busy      out  1                high while state != IDLE
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; every pe_cfg_port slice=0;
//    cfg_done=cfg_err=0; word counter=0. Reset mid-packet drops the packet;
//    the next accepted word is treated as a header.
//  - Accept = s_cfg_valid & s_cfg_ready.
//  - Header fields: [31]=bcast, [15:8]=cnt, [7:0]=pe_idx.
//  - Header is invalid if cnt==0, cnt>MAX_WORDS, or (!bcast & pe_idx>=NUM_PE).
//  - FSM states IDLE, DATA, DRAIN:
//    IDLE : s_cfg_ready=1. On accepted header:
//           valid & !last   -> DATA; latch dest, cnt; word counter=0.
//           invalid & !last -> DRAIN.
//           header with last asserted -> cfg_err next cycle; stay IDLE.
//    DATA : s_cfg_ready = !stall_t, where stall_t = pe_cfg_stall[dest],
//           or |pe_cfg_stall on broadcast.
//           Accepted word k (1-based) drives its target slice(s) next cycle.
//           last & k==cnt -> cfg_done next cycle; go to IDLE.
//           last & k<cnt  -> cfg_err next cycle; go to IDLE
//                            (words already sent are not retracted).
//           !last & k==cnt -> go to DRAIN.
//    DRAIN: s_cfg_ready=1; discard words.
//           On accepted last -> cfg_err next cycle; go to IDLE.
//  - Latency: exactly 1 cycle from accepting a data word to its strobe on
//    pe_cfg_port. Outputs are registered, not combinational.
//  - Strobes: each slice's valid bit is high 1 cycle per delivered word;
//    slice = 0 otherwise. Non-target slices stay 0.
//  - Back-to-back: a header may be accepted in the cycle after a packet's last
//    word; a full packet can stream at 1 word/cycle with no bubble.
//  - Stall asserted while s_cfg_valid is high: no accept and no strobe;
//    the source holds its data.
//  - cfg_done and cfg_err are never high in the same cycle.
//  - cfg_busy = (state != IDLE).
// STRUCTURE
//  - pe_cfg_pkg holds: state typedef (IDLE/DATA/DRAIN), header field
//    offsets/widths (HDR_BCAST_BIT, HDR_CNT_LSB/W, HDR_IDX_LSB/W), and
//    the BCAST constant.
//  - Single module; header decode is an inline function, no sub-module.
// TESTING
//  - Unicast: header {bcast=0,cnt=2,idx=1}, data 0x0, 0x2 (last)
//    -> slice1 = {1,0x0} then {1,0x2} on consecutive cycles; cfg_done one
//    cycle after 0x2; other slices stay 0.
//  - Broadcast: header {bcast=1,cnt=1}, data 0x5 (last)
//    -> all slices = {1,0x5} in the same cycle; cfg_done.
//  - Short packet: cnt=3, last on 2nd data word
//    -> 2 strobes delivered, cfg_err pulse, next word accepted as header.
//  - Bad header: idx=NUM_PE, 2 data words, last
//    -> no strobes; s_cfg_ready stays 1; cfg_err after last.
//  - Stall: pe_cfg_stall[1]=1 for 3 cycles mid-packet to PE1
//    -> s_cfg_ready=0 for those cycles, no strobe, no word lost.
//  - Reset mid-DATA -> outputs 0 immediately; next word decoded as header.

Source files
------------

// File: rtl/pe_cfg_pkg.sv
// Shared types and header layout for the PE configuration dispatcher.
// Header word: [31]=broadcast, [15:8]=data word count, [7:0]=target PE index.
package pe_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      DRAIN
   } state_e;

   localparam int HDR_BCAST_BIT = 31;
   localparam int HDR_CNT_LSB   = 8;
   localparam int HDR_CNT_W     = 8;
   localparam int HDR_IDX_LSB   = 0;
   localparam int HDR_IDX_W     = 8;

   localparam logic BCAST = 1'b1;

   typedef struct packed {
      logic                 bcast;
      logic [HDR_CNT_W-1:0] cnt;
      logic [HDR_IDX_W-1:0] idx;
      logic                 ok;
   } hdr_t;

endpackage

// File: rtl/pe_cfg_dispatcher.sv
// Streams header+data configuration packets from one valid/ready source to
// NUM_PE PE config ports as registered one-cycle {valid,word} strobes.
module pe_cfg_dispatcher
   import pe_cfg_pkg::*;
#(
   parameter int NUM_PE    = 4,
   parameter int CFG_W     = 32,
   parameter int MAX_WORDS = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         s_cfg_valid,
   output logic                         s_cfg_ready,
   input  logic [CFG_W-1:0]             s_cfg_data,
   input  logic                         s_cfg_last,
   input  logic [NUM_PE-1:0]            pe_cfg_stall,
   output logic [NUM_PE*(CFG_W+1)-1:0]  pe_cfg_port,
   output logic                         cfg_done,
   output logic                         cfg_err,
   output logic                         cfg_busy
);

   localparam int             PORT_W    = CFG_W + 1;
   localparam logic [8:0]     MAX_W9    = 9'(MAX_WORDS);
   localparam logic [8:0]     NUM_PE9   = 9'(NUM_PE);

   state_e                       state_q, state_d;
   logic [HDR_IDX_W-1:0]         dest_q, dest_d;
   logic                         bcast_q, bcast_d;
   logic [HDR_CNT_W-1:0]         cnt_q, cnt_d;
   logic [HDR_CNT_W-1:0]         wcnt_q, wcnt_d;
   logic [NUM_PE*PORT_W-1:0]     port_q, port_d;
   logic                         done_q, done_d;
   logic                         err_q, err_d;

   logic                         stall_t;
   logic                         accept;
   logic [HDR_CNT_W-1:0]         word_k;
   hdr_t                         hdr;

   function automatic hdr_t decode_hdr(input logic [CFG_W-1:0] w);
      hdr_t h;
      h.bcast = w[HDR_BCAST_BIT];
      h.cnt   = w[HDR_CNT_LSB +: HDR_CNT_W];
      h.idx   = w[HDR_IDX_LSB +: HDR_IDX_W];
      h.ok    = (h.cnt != '0) && ({1'b0, h.cnt} <= MAX_W9) &&
                ((h.bcast == BCAST) || ({1'b0, h.idx} < NUM_PE9));
      return h;
   endfunction

   // Broadcast waits for every PE; unicast only for its own target.
   always_comb begin
      stall_t = 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (bcast_q || (dest_q == 8'(i))) stall_t = stall_t | pe_cfg_stall[i];
      end
   end

   assign s_cfg_ready = (state_q != DATA) || !stall_t;
   assign accept      = s_cfg_valid && s_cfg_ready;
   assign hdr         = decode_hdr(s_cfg_data);
   assign word_k      = wcnt_q + 8'd1;

   always_comb begin
      // NOTE: every next-state signal is defaulted first so no latch is inferred.
      state_d = state_q;
      dest_d  = dest_q;
      bcast_d = bcast_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      port_d  = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (s_cfg_last) begin
                  err_d = 1'b1;
               end else if (hdr.ok) begin
                  state_d = DATA;
                  dest_d  = hdr.idx;
                  bcast_d = hdr.bcast;
                  cnt_d   = hdr.cnt;
                  wcnt_d  = '0;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DATA: begin
            if (accept) begin
               for (int i = 0; i < NUM_PE; i++) begin
                  if (bcast_q || (dest_q == 8'(i))) port_d[i*PORT_W +: PORT_W] = {1'b1, s_cfg_data};
               end
               wcnt_d = word_k;
               if (s_cfg_last) begin
                  done_d  = (word_k == cnt_q);
                  err_d   = (word_k != cnt_q);
                  state_d = IDLE;
               end else if (word_k == cnt_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (accept && s_cfg_last) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         dest_q  <= '0;
         bcast_q <= 1'b0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         port_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q <= state_d;
         dest_q  <= dest_d;
         bcast_q <= bcast_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         port_q  <= port_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign pe_cfg_port = port_q;
   assign cfg_done    = done_q;
   assign cfg_err     = err_q;
   assign cfg_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_pe_cfg_dispatcher.sv
// Scoreboard bench: a behavioural model queues expected strobes/status stamped
// with the cycle they must appear; a negedge monitor pops and compares.
module tb_pe_cfg_dispatcher;
   import pe_cfg_pkg::*;

   localparam int NUM_PE    = 4;
   localparam int CFG_W     = 32;
   localparam int MAX_WORDS = 8;
   localparam int PW        = CFG_W + 1;
   localparam int TOT       = NUM_PE * PW;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              s_cfg_valid = 1'b0;
   logic              s_cfg_ready;
   logic [CFG_W-1:0]  s_cfg_data = '0;
   logic              s_cfg_last = 1'b0;
   logic [NUM_PE-1:0] pe_cfg_stall = '0;
   logic [TOT-1:0]    pe_cfg_port;
   logic              cfg_done, cfg_err, cfg_busy;

   always #5 clk = ~clk;

   pe_cfg_dispatcher #(.NUM_PE(NUM_PE), .CFG_W(CFG_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_cfg_valid  (s_cfg_valid),
      .s_cfg_ready  (s_cfg_ready),
      .s_cfg_data   (s_cfg_data),
      .s_cfg_last   (s_cfg_last),
      .pe_cfg_stall (pe_cfg_stall),
      .pe_cfg_port  (pe_cfg_port),
      .cfg_done     (cfg_done),
      .cfg_err      (cfg_err),
      .cfg_busy     (cfg_busy)
   );

   typedef struct {
      int           cyc;
      logic [255:0] val;
   } sb_t;

   sb_t port_sb[$];
   sb_t stat_sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;

   // model state
   state_e m_state = IDLE;
   int     m_dest  = 0;
   logic   m_bcast = 1'b0;
   int     m_cnt   = 0;
   int     m_k     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] hdr(input logic b, input int cnt, input int idx);
      logic [31:0] r;
      r        = '0;
      r[31]    = b;
      r[15:8]  = 8'(cnt);
      r[7:0]   = 8'(idx);
      return r;
   endfunction

   function automatic logic m_ready();
      logic st;
      st = m_bcast ? (|pe_cfg_stall) : pe_cfg_stall[m_dest];
      return (m_state != DATA) || !st;
   endfunction

   task automatic push_stat(input logic [1:0] de, input int stamp);
      sb_t e;
      e.cyc = stamp;
      e.val = {254'b0, de};
      stat_sb.push_back(e);
   endtask

   task automatic model_accept(input logic [31:0] w, input logic last, input int stamp);
      sb_t e;
      int  cnt, idx;
      case (m_state)
         IDLE: begin
            cnt = int'(w[15:8]);
            idx = int'(w[7:0]);
            if (last) push_stat(2'b01, stamp);
            else if (cnt != 0 && cnt <= MAX_WORDS && (w[31] || idx < NUM_PE)) begin
               m_state = DATA;
               m_bcast = w[31];
               m_dest  = idx;
               m_cnt   = cnt;
               m_k     = 0;
            end else m_state = DRAIN;
         end
         DATA: begin
            e.cyc = stamp;
            e.val = '0;
            for (int i = 0; i < NUM_PE; i++)
               if (m_bcast || i == m_dest) e.val[i*PW +: PW] = {1'b1, w};
            port_sb.push_back(e);
            m_k++;
            if (last) begin
               push_stat((m_k == m_cnt) ? 2'b10 : 2'b01, stamp);
               m_state = IDLE;
            end else if (m_k == m_cnt) m_state = DRAIN;
         end
         default: begin
            if (last) begin
               push_stat(2'b01, stamp);
               m_state = IDLE;
            end
         end
      endcase
   endtask

   task automatic send(input logic [31:0] w, input logic last);
      int n;
      @(negedge clk);
      s_cfg_valid = 1'b1;
      s_cfg_data  = w;
      s_cfg_last  = last;
      #1;
      check("ready", {255'b0, s_cfg_ready}, {255'b0, m_ready()});
      n = 0;
      while (!s_cfg_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!s_cfg_ready) begin
         check("accept_timeout", {255'b0, s_cfg_ready}, 256'd1);
      end else begin
         model_accept(w, last, cyc + 1);
         @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      s_cfg_valid = 1'b0;
      s_cfg_last  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: an expectation due now must match; otherwise outputs must be 0.
   always @(negedge clk) begin
      if (reset) begin
         if (port_sb.size() > 0 && port_sb[0].cyc <= cyc) begin
            sb_t e;
            e = port_sb.pop_front();
            check("strobe", {124'b0, pe_cfg_port}, e.val);
         end else if (pe_cfg_port != '0) begin
            check("spurious_strobe", {124'b0, pe_cfg_port}, 256'b0);
         end
         if (stat_sb.size() > 0 && stat_sb[0].cyc <= cyc) begin
            sb_t e;
            e = stat_sb.pop_front();
            check("status", {254'b0, cfg_done, cfg_err}, e.val);
         end else if (cfg_done || cfg_err) begin
            check("spurious_status", {254'b0, cfg_done, cfg_err}, 256'b0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      check("rst_port", {124'b0, pe_cfg_port}, 256'b0);
      check("rst_status", {253'b0, cfg_done, cfg_err, cfg_busy}, 256'b0);
      #10 reset = 1'b1;
      idle(2);

      // Unicast to PE1, then broadcast back-to-back with no bubble.
      send(hdr(1'b0, 2, 1), 1'b0);
      send(32'h0, 1'b0);
      send(32'h2, 1'b1);
      send(hdr(1'b1, 1, 0), 1'b0);
      send(32'h5, 1'b1);

      // Short packet, then next word decoded as a header.
      send(hdr(1'b0, 3, 0), 1'b0);
      send(32'hA, 1'b0);
      send(32'hB, 1'b1);
      send(hdr(1'b0, 1, 3), 1'b0);
      send(32'hC0FFEE, 1'b1);

      // Bad headers: idx out of range, cnt=0, cnt>MAX; header with last.
      send(hdr(1'b0, 2, NUM_PE), 1'b0);
      send(32'h11, 1'b0);
      send(32'h22, 1'b1);
      send(hdr(1'b0, 0, 0), 1'b0);
      send(32'h33, 1'b1);
      send(hdr(1'b0, MAX_WORDS + 1, 2), 1'b0);
      send(32'h44, 1'b1);
      send(hdr(1'b0, 1, 2), 1'b1);
      idle(2);

      // Full-length packet and an overrun packet (extra word drained).
      send(hdr(1'b0, MAX_WORDS, 3), 1'b0);
      for (int i = 0; i < MAX_WORDS; i++) send($urandom, i == MAX_WORDS - 1);
      send(hdr(1'b0, 2, 2), 1'b0);
      send(32'h100, 1'b0);
      send(32'h200, 1'b0);
      send(32'h300, 1'b1);
      idle(1);

      // Stall PE1 for 3 cycles mid-packet.
      send(hdr(1'b0, 3, 1), 1'b0);
      send(32'hAAA, 1'b0);
      @(negedge clk);
      pe_cfg_stall = 4'b0010;
      s_cfg_valid  = 1'b1;
      s_cfg_data   = 32'hBBB;
      s_cfg_last   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_ready", {255'b0, s_cfg_ready}, 256'b0);
         @(negedge clk);
      end
      pe_cfg_stall = '0;
      #1;
      check("unstall_ready", {255'b0, s_cfg_ready}, 256'd1);
      model_accept(32'hBBB, 1'b0, cyc + 1);
      @(posedge clk);
      send(32'hCCC, 1'b1);
      idle(2);

      // Reset in the middle of a DATA phase.
      send(hdr(1'b0, 4, 2), 1'b0);
      send(32'hD1, 1'b0);
      @(negedge clk);
      s_cfg_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("midrst_port", {124'b0, pe_cfg_port}, 256'b0);
      check("midrst_status", {253'b0, cfg_done, cfg_err, cfg_busy}, 256'b0);
      m_state = IDLE;
      @(negedge clk);
      #2 reset = 1'b1;
      send(hdr(1'b0, 1, 3), 1'b0);
      send(32'hE1, 1'b1);

      idle(4);
      check("port_sb_empty", 256'(port_sb.size()), 256'b0);
      check("stat_sb_empty", 256'(stat_sb.size()), 256'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
